// File: rtl/imm_encoder.sv
// imm_encoder: RV32I immediate packer feeding an output FIFO.
// Scatters a 32-bit immediate into the I/S/B/J immediate fields of a base
// instruction, flags values that do not fit (or are misaligned for B/J), and
// queues {err, instr} in a DEPTH-entry FIFO with valid/ready handshakes.
// Optional round-trip self-check enabled by defining IMM_ENC_ROUNDTRIP_EN.
module imm_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_immsrc,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_base,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    input  logic             i_err_clr,
    output logic             o_rt_fail
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;
    localparam logic [1:0] SRC_J = 2'b11;

    logic [31:0] enc_instr;
    logic        enc_err;

    logic [32:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [32:0]      head;
    logic             push, pop;

    // Scatter the immediate into the selected format and range/alignment check it.
    // Out-of-range values are still encoded, fields simply truncated.
    always_comb begin
        enc_instr = i_base;
        enc_err   = 1'b0;
        case (i_immsrc)
            SRC_I: begin
                enc_instr[31:20] = i_imm[11:0];
                enc_err          = ~(&i_imm[31:11] | ~|i_imm[31:11]);
            end
            SRC_S: begin
                enc_instr[31:25] = i_imm[11:5];
                enc_instr[11:7]  = i_imm[4:0];
                enc_err          = ~(&i_imm[31:11] | ~|i_imm[31:11]);
            end
            SRC_B: begin
                enc_instr[31]    = i_imm[12];
                enc_instr[30:25] = i_imm[10:5];
                enc_instr[11:8]  = i_imm[4:1];
                enc_instr[7]     = i_imm[11];
                enc_err          = ~(&i_imm[31:12] | ~|i_imm[31:12]) | i_imm[0];
            end
            default: begin
                enc_instr[31]    = i_imm[20];
                enc_instr[30:21] = i_imm[10:1];
                enc_instr[20]    = i_imm[11];
                enc_instr[19:12] = i_imm[19:12];
                enc_err          = ~(&i_imm[31:20] | ~|i_imm[31:20]) | i_imm[0];
            end
        endcase
    end

    // Ready depends only on the registered count, so a full FIFO never
    // accepts in the same cycle it is popped.
    assign o_ready = (count_q != FULL);
    assign o_valid = (count_q != '0);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;
    assign head    = mem_q[rd_ptr_q];
    assign o_instr = o_valid ? head[31:0] : 32'h0;
    assign o_err   = o_valid & head[32];
    assign o_err_cnt = err_cnt_q;

    // Next-state for pointers, occupancy and the saturating error counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (i_err_clr) begin
            err_cnt_d = (push & enc_err) ? CNT_W'(1) : '0;
        end else if (push & enc_err & ~&err_cnt_q) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Control state register; reset empties the FIFO immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {enc_err, enc_instr};
    end

`ifdef IMM_ENC_ROUNDTRIP_EN
    logic [31:0] rt_ext, rt_exp;
    logic        rt_fail_q, rt_fail_d;

    // Re-extract the immediate as the core's extender would and compare it
    // with the sign-truncated (and for B/J, even) input immediate.
    always_comb begin
        rt_ext = '0;
        rt_exp = '0;
        case (i_immsrc)
            SRC_I: begin
                rt_ext = {{20{enc_instr[31]}}, enc_instr[31:20]};
                rt_exp = {{20{i_imm[11]}}, i_imm[11:0]};
            end
            SRC_S: begin
                rt_ext = {{20{enc_instr[31]}}, enc_instr[31:25], enc_instr[11:7]};
                rt_exp = {{20{i_imm[11]}}, i_imm[11:0]};
            end
            SRC_B: begin
                rt_ext = {{19{enc_instr[31]}}, enc_instr[31], enc_instr[7],
                          enc_instr[30:25], enc_instr[11:8], 1'b0};
                rt_exp = {{19{i_imm[12]}}, i_imm[12:1], 1'b0};
            end
            default: begin
                rt_ext = {{11{enc_instr[31]}}, enc_instr[31], enc_instr[19:12],
                          enc_instr[20], enc_instr[30:21], 1'b0};
                rt_exp = {{11{i_imm[20]}}, i_imm[20:1], 1'b0};
            end
        endcase
        rt_fail_d = rt_fail_q | (push & ~enc_err & (rt_ext != rt_exp));
    end

    // Sticky failure flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rt_fail_q <= 1'b0;
        else          rt_fail_q <= rt_fail_d;
    end

    assign o_rt_fail = rt_fail_q;
`else
    assign o_rt_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder (DEPTH=4, CNT_W=8).
module tb_imm_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_immsrc;
    logic [31:0] i_imm;
    logic [31:0] i_base;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic        o_err;
    logic [7:0]  o_err_cnt;
    logic        i_err_clr;
    logic        o_rt_fail;

    int checks = 0;
    int errors = 0;

    imm_encoder #(.DEPTH(4), .CNT_W(8)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_immsrc  (i_immsrc),
        .i_imm     (i_imm),
        .i_base    (i_base),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_instr   (o_instr),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .i_err_clr (i_err_clr),
        .o_rt_fail (o_rt_fail)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] imm,
                         input logic [31:0] base);
        i_valid  = v;
        i_immsrc = src;
        i_imm    = imm;
        i_base   = base;
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b, want 0 1", o_valid, o_ready);
        end
        checks++;
        if (o_instr !== 32'h0 || o_err !== 1'b0 || o_err_cnt !== 8'd0 || o_rt_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: instr=%h err=%b cnt=%0d rt=%b, want 0 0 0 0",
                     o_instr, o_err, o_err_cnt, o_rt_fail);
        end
    endtask

    task automatic test_formats();
        logic [1:0]  src  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] imm  [4] = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'h800};
        logic [31:0] base [4] = '{32'h00000093, 32'h00202023, 32'h00000063, 32'h000000EF};
        logic [31:0] exp  [4] = '{32'h00500093, 32'h00202423, 32'hFE000EE3, 32'h001000EF};
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, src[k], imm[k], base[k]);
            step();
            drive(1'b0, 2'b00, 32'h0, 32'h0);
            checks++;
            if (o_valid !== 1'b1 || o_instr !== exp[k] || o_err !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d: valid=%b instr=%h err=%b, want 1 %h 0",
                         k, o_valid, o_instr, o_err, exp[k]);
            end
            step();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d_pop: valid=%b, want 0", k, o_valid);
            end
        end
    endtask

    task automatic test_errors();
        i_ready = 1'b1;
        drive(1'b1, 2'b00, 32'd2048, 32'h00000093);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_instr !== 32'h80000093 || o_err !== 1'b1 || o_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_i: instr=%h err=%b cnt=%0d, want 80000093 1 1",
                     o_instr, o_err, o_err_cnt);
        end
        drive(1'b1, 2'b10, 32'd3, 32'h00000063);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_instr !== 32'h00000163 || o_err !== 1'b1 || o_err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL err_b: instr=%h err=%b cnt=%0d, want 00000163 1 2",
                     o_instr, o_err, o_err_cnt);
        end
        i_err_clr = 1'b1;
        drive(1'b1, 2'b11, 32'h00100000, 32'h0000006F);
        step();
        i_err_clr = 1'b0;
        checks++;
        if (o_err !== 1'b1 || o_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_clr_push: err=%b cnt=%0d, want 1 1", o_err, o_err_cnt);
        end
        drive(1'b1, 2'b01, 32'hFFFFF7FF, 32'h00002023);
        for (int k = 0; k < 253; k++) step();
        checks++;
        if (o_err_cnt !== 8'd254) begin
            errors++;
            $display("FAIL err_254: cnt=%0d, want 254", o_err_cnt);
        end
        for (int k = 0; k < 11; k++) step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_sat: cnt=%0d, want 255", o_err_cnt);
        end
        step();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        checks++;
        if (o_err_cnt !== 8'd0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: cnt=%0d valid=%b, want 0 0", o_err_cnt, o_valid);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 2'b00, 32'(k), 32'h00000013);
            step();
        end
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_instr !== 32'h00100013) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b instr=%h, want 0 1 00100013",
                     o_ready, o_valid, o_instr);
        end
        drive(1'b1, 2'b00, 32'd5, 32'h00000013);
        step();
        checks++;
        if (o_ready !== 1'b0 || o_instr !== 32'h00100013) begin
            errors++;
            $display("FAIL bp_hold: ready=%b instr=%h, want 0 00100013", o_ready, o_instr);
        end
        i_ready = 1'b1;
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_ready !== 1'b1 || o_instr !== 32'h00200013) begin
            errors++;
            $display("FAIL bp_full_pop: ready=%b instr=%h, want 1 00200013", o_ready, o_instr);
        end
        for (int k = 3; k <= 4; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_instr !== ((32'(k) << 20) | 32'h13)) begin
                errors++;
                $display("FAIL bp_order%0d: valid=%b instr=%h, want 1 %h",
                         k, o_valid, o_instr, (32'(k) << 20) | 32'h13);
            end
        end
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b, want 0", o_valid);
        end
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd100, 32'h00000013);
        step();
        i_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 2'b00, 32'(100 + k), 32'h00000013);
            step();
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b1 ||
                o_instr !== ((32'(100 + k) << 20) | 32'h13)) begin
                errors++;
                $display("FAIL b2b%0d: valid=%b ready=%b instr=%h, want 1 1 %h",
                         k, o_valid, o_ready, o_instr, (32'(100 + k) << 20) | 32'h13);
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd4096, 32'h00000013);
        step();
        drive(1'b1, 2'b00, 32'd7, 32'h00000013);
        step();
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_err_cnt !== 8'd1 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: cnt=%0d valid=%b, want 1 1", o_err_cnt, o_valid);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_err_cnt !== 8'd0 || o_instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: valid=%b ready=%b cnt=%0d instr=%h, want 0 1 0 0",
                     o_valid, o_ready, o_err_cnt, o_instr);
        end
        #2;
        i_rst_n = 1'b1;
        step();
        i_ready = 1'b1;
        drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'h00000023);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (o_valid !== 1'b1 || o_instr !== 32'hFE000FA3 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_first: valid=%b instr=%h err=%b, want 1 fe000fa3 0",
                     o_valid, o_instr, o_err);
        end
        step();
    endtask

`ifdef IMM_ENC_ROUNDTRIP_EN
    task automatic test_roundtrip();
        logic [31:0] r;
        logic [1:0]  s;
        i_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            r = $urandom;
            s = 2'(k % 4);
            case (s)
                2'b00, 2'b01: r = {{20{r[11]}}, r[11:0]};
                2'b10:        r = {{19{r[12]}}, r[12:1], 1'b0};
                default:      r = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            drive(1'b1, s, r, $urandom);
            step();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        checks++;
        if (o_rt_fail !== 1'b0 || o_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL roundtrip: rt=%b cnt=%0d, want 0 0", o_rt_fail, o_err_cnt);
        end
    endtask
`endif

    initial begin
        i_rst_n   = 1'b0;
        i_ready   = 1'b0;
        i_err_clr = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #12;
        test_reset();
        #5;
        i_rst_n = 1'b1;
        step();
        test_formats();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef IMM_ENC_ROUNDTRIP_EN
        test_roundtrip();
`endif
        checks++;
        if (o_rt_fail !== 1'b0) begin
            errors++;
            $display("FAIL rt_sticky: rt=%b, want 0", o_rt_fail);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Immediate encoder / instruction packer, the inverse of the core's immediate extender. Takes a base instruction word plus a 32-bit immediate and format selector. Scatters the immediate into the RV32I bit fields, range/alignment-checks it, and queues the result in an output FIFO. Used by the test-program generator and instruction-memory loader to build I/S/B/J instructions that feed the single-cycle core.

Parameters:
DEPTH, 4, output FIFO entries; power of two, >= 2
CNT_W, 8, width of saturating error counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_valid  input  1  upstream word valid
o_ready  output  1  block can accept a word
i_immsrc  input  2  format select: 00 I, 01 S, 10 B, 11 J
i_imm  input  32  immediate value, two's complement, byte offset for B/J
i_base  input  32  instruction with opcode/rd/rs1/rs2/funct fields; immediate bit positions ignored
o_valid  output  1  FIFO head valid
i_ready  input  1  downstream accepts head
o_instr  output  32  encoded instruction at FIFO head
o_err  output  1  range/alignment error flag travelling with o_instr
o_err_cnt  output  CNT_W  saturating count of errored words accepted
i_err_clr  input  1  synchronous clear of o_err_cnt
o_rt_fail  output  1  sticky round-trip self-check failure (see Optional Feature)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. While in reset, FIFO is empty, pointers are 0, o_valid=0, o_ready=1, o_err_cnt=0, o_rt_fail=0. o_instr and o_err are 32'h0 and 0 when the FIFO is empty.
- Push and pop:
  - Push = i_valid & o_ready. Pop = o_valid & i_ready.
  - o_ready = (count != DEPTH). It depends only on registered count, never on i_ready; a full FIFO does not accept even if a pop occurs that cycle.
  - Simultaneous push and pop when not full or empty: count unchanged, both pointers advance.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Latency: a word pushed in cycle N is visible at o_instr/o_valid in cycle N+1 if the FIFO was empty. Strict FIFO order.
- Encoding is combinational before the FIFO write. Bits not listed below come from i_base.
  - I: instr[31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Range check. Error = 1 if the immediate does not fit:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
- On error the word is still encoded (fields truncated, imm[0] dropped) and pushed with o_err=1.
- o_err_cnt:
  - Increments on each push with error.
  - Saturates at all-ones.
  - i_err_clr wins over hold; i_err_clr together with an errored push gives 1.
- Reset mid-stream discards all queued words immediately. No output handshake completes in the reset cycle.

Optional Feature:
Macro IMM_ENC_ROUNDTRIP_EN.
- Defined: on each push, the encoded word is re-extracted using the core's immediate-extension mapping for i_immsrc and compared with the expected value. Expected value is i_imm sign-truncated to the format width, with bit0 forced to 0 for B/J. On a mismatch with o_err=0, o_rt_fail sets and stays set until reset.
- Undefined: checker logic absent; o_rt_fail tied to 0.

Test Plan:
- I-type: base 0x00000093, imm 5, i_ready=1 -> next cycle o_instr=0x00500093, o_err=0, o_valid=1.
- S/B/J:
  - S: base 0x00202023, imm 8 -> 0x00202423.
  - B: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3.
  - J: base 0x000000EF, imm 0x800 -> 0x001000EF.
  - All with o_err=0.
- Errors:
  - I imm 2048, base 0x00000093 -> 0x80000093, o_err=1, o_err_cnt=1.
  - B imm 3 -> o_err=1, cnt=2.
  - Then i_err_clr with an errored push -> cnt=1.
  - Force 255 errors with CNT_W=8 -> cnt holds 255.
- Backpressure: i_ready=0, push 4 words -> o_ready=0 after 4th, 5th i_valid not accepted. Release i_ready -> 4 words out in push order. Continuous push+pop keeps count steady across pointer wrap.
- Reset: assert i_rst_n low with 3 queued words -> o_valid=0, o_ready=1, o_err_cnt=0 asynchronously, before the next edge. First push after reset is output in cycle N+1.
- With IMM_ENC_ROUNDTRIP_EN: 1000 random valid (in-range, aligned) immediates across all formats -> o_rt_fail stays 0.
